// File: rtl/multiword_add_seq_pkg.sv
// Shared definitions for the multi-word add sequencer: FSM state encoding
// and a constant-evaluable ceil(log2) used to size the word index.
package multiword_add_seq_pkg;

   // Encoding 2'd3 is unused and is decoded as idle by the sequencer.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) begin
         r = r + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/adder_top.sv
// Registered W-bit adder with carry: sum and carry appear one cycle after
// the operands are presented.
module adder_top #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         c_in,
   output logic [W-1:0] sum,
   output logic         c_out
);

   logic [W:0] acc_d;
   logic [W:0] acc_q;

   always_comb begin
      acc_d = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c_in};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign sum   = acc_q[W-1:0];
   assign c_out = acc_q[W];

endmodule

// File: rtl/multiword_add_seq.sv
// Sequences an external registered W-bit adder over NWORDS words, least
// significant first, chaining the adder's registered carry between words.
module multiword_add_seq
   import multiword_add_seq_pkg::*;
#(
   parameter int W      = 16,
   parameter int NWORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [W*NWORDS-1:0]   op_a,
   input  logic [W*NWORDS-1:0]   op_b,
   input  logic                  c_in,
   output logic                  busy,
   output logic                  done,
   output logic [W*NWORDS-1:0]   result,
   output logic                  c_out,
   output logic [W-1:0]          add_a,
   output logic [W-1:0]          add_b,
   output logic                  add_cin,
   input  logic [W-1:0]          add_sum,
   input  logic                  add_cout
);

   localparam int IW = clog2(NWORDS);
   localparam int OW = W * NWORDS;

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [OW-1:0]   opa_q, opa_d;
   logic [OW-1:0]   opb_q, opb_d;
   logic            cin_q, cin_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [OW-1:0]   result_q, result_d;
   logic            cout_q, cout_d;

   // The adder output lags by one word, so RUN at index i retires word i-1.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      cin_d    = cin_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      result_d = result_q;
      cout_d   = cout_q;
      case (state_q)
         ST_RUN: begin
            idx_d = idx_q + 1'b1;
            for (int i = 1; i < NWORDS; i++) begin
               if (idx_q == IW'(i)) begin
                  result_d[(i-1)*W +: W] = add_sum;
               end
            end
            if (idx_q == IW'(NWORDS - 1)) begin
               idx_d   = idx_q;
               state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            result_d[(NWORDS-1)*W +: W] = add_sum;
            cout_d  = add_cout;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            idx_d   = '0;
            state_d = ST_IDLE;
         end
         default: begin
            if (start) begin
               opa_d   = op_a;
               opb_d   = op_b;
               cin_d   = c_in;
               idx_d   = '0;
               busy_d  = 1'b1;
               state_d = ST_RUN;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         cin_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         cout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         cin_q    <= cin_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
         cout_q   <= cout_d;
      end
   end

   // Word 0 takes the operation's carry-in; later words take the adder's carry.
   always_comb begin
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
      if (state_q == ST_RUN) begin
         for (int i = 0; i < NWORDS; i++) begin
            if (idx_q == IW'(i)) begin
               add_a = opa_q[i*W +: W];
               add_b = opb_q[i*W +: W];
            end
         end
         add_cin = (idx_q == '0) ? cin_q : add_cout;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign c_out  = cout_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Self-checking bench: sequencer plus adder_top in loop, compared every cycle
// against a word-level arithmetic model, with directed literal expectations.
module tb_multiword_add_seq;

   localparam int W      = 16;
   localparam int NWORDS = 4;
   localparam int OW     = W * NWORDS;

   logic            clk   = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic            c_in  = 1'b0;
   logic [OW-1:0]   op_a  = '0;
   logic [OW-1:0]   op_b  = '0;

   logic            busy;
   logic            done;
   logic [OW-1:0]   result;
   logic            c_out;
   logic [W-1:0]    add_a;
   logic [W-1:0]    add_b;
   logic            add_cin;
   logic [W-1:0]    add_sum;
   logic            add_cout;

   int n_checks   = 0;
   int n_fail     = 0;
   int done_count = 0;

   always #5 clk = ~clk;

   multiword_add_seq #(.W(W), .NWORDS(NWORDS)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .op_a     (op_a),
      .op_b     (op_b),
      .c_in     (c_in),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .c_out    (c_out),
      .add_a    (add_a),
      .add_b    (add_b),
      .add_cin  (add_cin),
      .add_sum  (add_sum),
      .add_cout (add_cout)
   );

   adder_top #(.W(W)) u_adder (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (add_a),
      .b     (add_b),
      .c_in  (add_cin),
      .sum   (add_sum),
      .c_out (add_cout)
   );

   task automatic checkOutput(input string name, input logic [64:0] act, input logic [64:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Carry into word k of a + b + ci, from plain wide arithmetic on the low k words.
   function automatic logic carryInto(input int k, input logic [OW-1:0] a, input logic [OW-1:0] b, input logic ci);
      logic [OW:0] mask;
      logic [OW:0] s;
      if (k == 0) return ci;
      mask = ((OW+1)'(1) << (k*W)) - (OW+1)'(1);
      s = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {{OW{1'b0}}, ci};
      return s[k*W];
   endfunction

   // Model: m_p counts edges since acceptance (0 = idle); done NWORDS+1 edges later.
   int            m_p      = 0;
   logic          m_done   = 1'b0;
   logic [OW-1:0] m_result = '0;
   logic          m_cout   = 1'b0;
   logic [OW-1:0] m_a      = '0;
   logic [OW-1:0] m_b      = '0;
   logic          m_cin    = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      logic [OW:0] full;
      if (!rst_n) begin
         m_p      = 0;
         m_done   = 1'b0;
         m_result = '0;
         m_cout   = 1'b0;
      end else begin
         m_done = 1'b0;
         if (m_p == 0) begin
            if (start) begin
               m_a   = op_a;
               m_b   = op_b;
               m_cin = c_in;
               m_p   = 1;
            end
         end else if (m_p == NWORDS + 1) begin
            full     = {1'b0, m_a} + {1'b0, m_b} + {{OW{1'b0}}, m_cin};
            m_result = full[OW-1:0];
            m_cout   = full[OW];
            m_done   = 1'b1;
            m_p      = 0;
         end else begin
            m_p = m_p + 1;
         end
      end
   end

   always @(negedge clk) begin
      int k;
      logic [W-1:0] ea;
      logic [W-1:0] eb;
      logic         ecin;
      ea   = '0;
      eb   = '0;
      ecin = 1'b0;
      if (m_p >= 1 && m_p <= NWORDS) begin
         k    = m_p - 1;
         ea   = m_a[k*W +: W];
         eb   = m_b[k*W +: W];
         ecin = carryInto(k, m_a, m_b, m_cin);
      end
      checkOutput("busy", 65'(busy), 65'(m_p != 0));
      checkOutput("done", 65'(done), 65'(m_done));
      checkOutput("add_a", 65'(add_a), 65'(ea));
      checkOutput("add_b", 65'(add_b), 65'(eb));
      checkOutput("add_cin", 65'(add_cin), 65'(ecin));
      if (m_p == 0) begin
         checkOutput("result", 65'(result), 65'(m_result));
         checkOutput("c_out", 65'(c_out), 65'(m_cout));
      end
      if (done) done_count++;
   end

   task automatic applyStimulus(input logic [OW-1:0] a, input logic [OW-1:0] b, input logic ci,
                                output int lat, output int busy_cycles);
      @(posedge clk); #1;
      op_a  = a;
      op_b  = b;
      c_in  = ci;
      start = 1'b1;
      @(posedge clk); #1;
      start       = 1'b0;
      busy_cycles = busy ? 1 : 0;
      lat         = -1;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk); #1;
         if (busy) busy_cycles++;
         if (done) begin
            lat = n;
            break;
         end
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int lat;
      int bc;
      int dc0;
      int done_at[$];

      #2;
      checkOutput("rst_busy", 65'(busy), 65'd0);
      checkOutput("rst_done", 65'(done), 65'd0);
      checkOutput("rst_result", 65'(result), 65'd0);
      checkOutput("rst_add_a", 65'(add_a), 65'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, lat, bc);
      checkOutput("t1_latency", 65'(lat), 65'd5);
      checkOutput("t1_busy_cycles", 65'(bc), 65'd5);
      checkOutput("t1_result", 65'(result), 65'd0);
      checkOutput("t1_c_out", 65'(c_out), 65'd1);

      applyStimulus(64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1'b1, lat, bc);
      checkOutput("t2_latency", 65'(lat), 65'd5);
      checkOutput("t2_result", 65'(result), 65'h0011_0022_0033_0045);
      checkOutput("t2_c_out", 65'(c_out), 65'd0);

      applyStimulus(64'h0000_FFFF_FFFF_0000, 64'h0000_0000_0001_0000, 1'b0, lat, bc);
      checkOutput("t3_result", 65'(result), 65'h0001_0000_0000_0000);
      checkOutput("t3_c_out", 65'(c_out), 65'd0);

      // Starts mid-run and during flush must be ignored.
      @(posedge clk); #1;
      op_a  = 64'h1234_5678_9ABC_DEF0;
      op_b  = 64'h1111_1111_1111_1111;
      c_in  = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      dc0   = done_count;
      @(posedge clk); #1;
      op_a  = 64'hFFFF_FFFF_FFFF_FFFF;
      op_b  = 64'hFFFF_FFFF_FFFF_FFFF;
      c_in  = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checkOutput("t4_done", 65'(done), 65'd1);
      checkOutput("t4_result", 65'(result), 65'h2345_6789_ABCD_F001);
      checkOutput("t4_c_out", 65'(c_out), 65'd0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("t4_done_count", 65'(done_count - dc0), 65'd1);
      checkOutput("t4_idle", 65'(busy), 65'd0);

      // Reset in the middle of an operation.
      @(posedge clk); #1;
      op_a  = 64'h0F0F_0F0F_0F0F_0F0F;
      op_b  = 64'h0101_0101_0101_0101;
      c_in  = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      dc0   = done_count;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      checkOutput("t5_busy", 65'(busy), 65'd0);
      checkOutput("t5_done", 65'(done), 65'd0);
      checkOutput("t5_result", 65'(result), 65'd0);
      checkOutput("t5_c_out", 65'(c_out), 65'd0);
      checkOutput("t5_add_a", 65'(add_a), 65'd0);
      checkOutput("t5_add_b", 65'(add_b), 65'd0);
      checkOutput("t5_add_cin", 65'(add_cin), 65'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      checkOutput("t5_no_done", 65'(done_count - dc0), 65'd0);
      applyStimulus(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, lat, bc);
      checkOutput("t5_latency", 65'(lat), 65'd5);
      checkOutput("t5_new_result", 65'(result), 65'd1);
      checkOutput("t5_new_c_out", 65'(c_out), 65'd1);

      // Start held high: a new op every NWORDS+2 cycles.
      @(posedge clk); #1;
      op_a  = 64'h0000_0000_FFFF_FFFF;
      op_b  = 64'd1;
      c_in  = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      for (int k = 1; k <= 17; k++) begin
         @(posedge clk); #1;
         if (done) done_at.push_back(k);
      end
      start = 1'b0;
      checkOutput("t6_done_count", 65'(done_at.size()), 65'd3);
      if (done_at.size() == 3) begin
         checkOutput("t6_done0", 65'(done_at[0]), 65'd5);
         checkOutput("t6_done1", 65'(done_at[1]), 65'd11);
         checkOutput("t6_done2", 65'(done_at[2]), 65'd17);
      end
      checkOutput("t6_result", 65'(result), 65'h0000_0001_0000_0000);
      repeat (8) @(posedge clk);
      #1;
      checkOutput("t6_idle", 65'(busy), 65'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
